// File: rtl/mont_enter_pkg.sv
// Shared constants and state encoding for the Montgomery-domain entry engine.
// Modulus, R = 2^65 and the derived residues used by the modexp datapath.
package mont_enter_pkg;

  localparam int W      = 65;
  localparam int R_LOG2 = 65;
  localparam int CNT_W  = $clog2(R_LOG2);

  localparam logic [W-1:0] N        = 65'd21536215303153667899;
  localparam logic [W-1:0] R_MOD_N  = 65'd15357272844265435333;
  localparam logic [W-1:0] R2_MOD_N = 65'd15661607970342841481;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R_LOG2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mont_enter_if.sv
// Operand/result handshake bundle between the modexp sequencer and mont_enter.
interface mont_enter_if;
  import mont_enter_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic         busy;

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, x, busy
  );

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, x, busy
  );

endinterface

// File: rtl/mont_enter_dbl_step.sv
// One modular doubling step: out = (dbl_en ? 2*acc : acc) mod N.
// With dbl_en low it performs the single conditional subtract used to normalise a raw operand.
module mod_dbl_step
  import mont_enter_pkg::*;
(
  input  logic [W-1:0] acc,
  input  logic         dbl_en,
  output logic [W-1:0] out
);

  localparam logic [W:0] N_EXT = {1'b0, N};

  logic [W:0] t;

  // Input is always < 2N, so one subtraction lands in [0, N).
  always_comb begin
    t = dbl_en ? {acc, 1'b0} : {1'b0, acc};
    if (t >= N_EXT) begin
      out = W'(t - N_EXT);
    end else begin
      out = t[W-1:0];
    end
  end

endmodule

// File: rtl/mont_enter.sv
// Montgomery-domain entry: x = a * 2^65 mod N by 65 sequential doubling-mod steps.
//   state | meaning
//   IDLE  | waiting for an operand, in_ready high
//   NORM  | reduce raw operand below N once
//   DBL   | one modular doubling per cycle, cnt counts steps
//   DONE  | result held on x with out_valid until accepted
module mont_enter
  import mont_enter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mont_enter_if.slave  bus
);

  state_e             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       x_q, x_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [W-1:0]       step_out;

  mod_dbl_step u_step (
    .acc    (acc_q),
    .dbl_en (state_q == DBL),
    .out    (step_out)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.a;
          state_d = NORM;
          busy_d  = 1'b1;
        end
      end
      NORM: begin
        acc_d   = step_out;
        cnt_d   = '0;
        state_d = DBL;
      end
      DBL: begin
        acc_d = step_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          x_d         = step_out;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      x_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mont_enter.sv
// Self-checking bench for mont_enter: directed vector table, backpressure and reset
// sequences, and random operands against an a*2^65 mod N arithmetic model.
module tb_mont_enter;
  import mont_enter_pkg::*;

  localparam int LAT    = 66;
  localparam int N_RAND = 400;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;

  mont_enter_if bus();

  mont_enter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [64:0] a;
    logic [64:0] x;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [64:0] model(input logic [64:0] av);
    logic [129:0] p;
    p = {av, 65'd0};
    return 65'(p % {65'd0, N});
  endfunction

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // result must never be presented unreduced
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) check("x_lt_n", {64'd0, bus.x < N}, 65'd1);
  end

  task automatic accept(input logic [64:0] av);
    bus.in_valid = 1'b1;
    bus.a        = av;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      if (n == 10) begin
        check({nm, "_inready_busy"}, {63'd0, bus.in_ready, bus.busy}, 65'd1);
      end
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_latency"}, 65'(n), 65'(LAT));
  endtask

  task automatic drain(input string nm, input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({nm, "_release"}, {62'd0, bus.out_valid, bus.in_ready, bus.busy}, 65'd2);
  endtask

  initial begin
    logic [64:0] x0;
    logic [95:0] r;
    logic [64:0] av;
    bit          stable;

    chk_cnt  = 0;
    pass_cnt = 0;

    vecs[0] = '{a: 65'd0,                       x: 65'd0};
    vecs[1] = '{a: 65'd1,                       x: 65'd15357272844265435333};
    vecs[2] = '{a: 65'd15357272844265435333,    x: 65'd15661607970342841481};
    vecs[3] = '{a: 65'd21536215303153667899,    x: 65'd0};
    vecs[4] = '{a: 65'h1_FFFF_FFFF_FFFF_FFFF,   x: 65'd304335126077406148};
    vecs[5] = '{a: 65'd2,                       x: 65'd9178330385377202767};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.out_ready = 1'b0;
    #12;
    check("reset_during", {bus.x, bus.in_ready, bus.out_valid, bus.busy} == 68'h4 ? 65'd1 : 65'd0, 65'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_after_flags", {62'd0, bus.in_ready, bus.out_valid, bus.busy}, 65'd4);
    check("reset_after_x", bus.x, 65'd0);

    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].a);
      wait_result($sformatf("vec%0d", i));
      check($sformatf("vec%0d_x", i), bus.x, vecs[i].x);
      drain($sformatf("vec%0d", i), i % 3);
    end

    // backpressure: result held, new operand ignored until accepted
    accept(65'd1);
    wait_result("bp");
    x0 = bus.x;
    check("bp_x", x0, 65'd15357272844265435333);
    bus.in_valid = 1'b1;
    bus.a        = 65'd5;
    stable       = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!(bus.out_valid && bus.x == x0 && !bus.in_ready && bus.busy)) stable = 1'b0;
    end
    check("bp_hold_stable", {64'd0, stable}, 65'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_to_idle", {63'd0, bus.out_valid, bus.in_ready}, 65'd1);
    check("bp_x_kept", bus.x, x0);
    accept(65'd5);
    wait_result("b2b");
    check("b2b_x", bus.x, model(65'd5));
    drain("b2b", 0);

    // reset while doubling, around cnt = 30
    accept(65'd1);
    repeat (31) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {62'd0, bus.out_valid, bus.in_ready, bus.busy}, 65'd2);
    check("midrst_x", bus.x, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    accept(65'd1);
    wait_result("postrst");
    check("postrst_x", bus.x, 65'd15357272844265435333);
    drain("postrst", 1);

    for (int i = 0; i < N_RAND; i++) begin
      r  = {$urandom(), $urandom(), $urandom()};
      av = r[64:0];
      accept(av);
      wait_result("rand");
      check($sformatf("rand%0d_x", i), bus.x, model(av));
      drain("rand", $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
